// File: rtl/dmem_rmw_ctrl_pkg.sv
// Shared types for the data-memory access controller: FSM states and dmem_access field layout.
// No logic, no latency.
// No flow control.
package dmem_rmw_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WR_PREP = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_B    = 2'b00,
        SZ_H    = 2'b01,
        SZ_W    = 2'b10,
        SZ_NONE = 2'b11
    } size_t;

    // Bit order matches dmem_access: [3]=store, [2]=sign-extend, [1:0]=size
    typedef struct packed {
        logic  store;
        logic  sext;
        size_t size;
    } acc_t;

    function automatic logic is_misaligned(input size_t size, input logic [1:0] addr_lo);
        return ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_rmw_ctrl_if.sv
// Word-aligned synchronous data RAM port; master = controller, slave = memory.
// Requests are held until a single-cycle mem_ack; read data is valid with the ack.
// Memory stretches a transaction by withholding mem_ack.
interface dmem_rmw_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_wait_timer.sv
// Per-state wait counter for memory acknowledges; expired flags the MAX_WAIT-th unacked cycle.
// expired is combinational from the current count and enable.
// No flow control; clr has priority over en.
module dmem_wait_timer #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WAIT_W-1:0] cnt;

    assign expired = en && (cnt == WAIT_W'(MAX_WAIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// MEM-stage data-memory controller: loads, word stores, and read-modify-write for sub-word stores.
// Load: request + ack wait + DONE; sub-word store adds one prep cycle and a write; optional misalign trap (DMEM_MISALIGN_TRAP_EN).
// Holds stall high until the access completes; memory throttles via mem_ack, timing out after MAX_WAIT.
module dmem_rmw_ctrl
    import dmem_rmw_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    input  logic [3:0]  dmem_access,
    input  logic [31:0] req_wdata,
    input  logic [31:0] sl_wd,
    output logic [31:0] raw_rdata,
    output logic        stall,
    output logic        done,
    output logic        bus_err,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    dmem_rmw_ctrl_if.master mem
);

    state_t state, state_nxt;
    acc_t   acc;
    logic   req_act;
    logic   trap;
    logic   is_store_q;
    logic   wait_exp;
    logic   [2:0] unused_bits;

    assign acc         = acc_t'(dmem_access);
    assign req_act     = req_valid && (acc.size != SZ_NONE);
    assign unused_bits = {acc.sext, req_addr[1:0]};

`ifdef DMEM_MISALIGN_TRAP_EN
    assign trap = is_misaligned(acc.size, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    dmem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_nxt != state),
        .en      (((state == RD) || (state == WR)) && !mem.mem_ack),
        .expired (wait_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (req_act) begin
                    stall = 1'b1;
                    if (trap) begin
                        state_nxt = DONE;
                    end else if (acc.store && (acc.size == SZ_W)) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                stall = 1'b1;
                if (mem.mem_ack) begin
                    state_nxt = is_store_q ? WR_PREP : DONE;
                end else if (wait_exp) begin
                    state_nxt = DONE;
                end
            end
            // One idle bus cycle so the alignment unit sees the freshly captured raw_rdata
            WR_PREP: begin
                stall     = 1'b1;
                state_nxt = WR;
            end
            WR: begin
                stall = 1'b1;
                if (mem.mem_ack || wait_exp) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_rdata     <= '0;
            bus_err       <= 1'b0;
            is_store_q    <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misalign      <= 1'b0;
`endif
        end else begin
            mem.mem_req <= (state_nxt == RD) || (state_nxt == WR);
            mem.mem_we  <= (state_nxt == WR);
            bus_err     <= wait_exp;
`ifdef DMEM_MISALIGN_TRAP_EN
            misalign    <= (state == IDLE) && req_act && trap;
`endif
            if ((state == IDLE) && ((state_nxt == RD) || (state_nxt == WR))) begin
                mem.mem_addr <= {req_addr[31:2], 2'b00};
                is_store_q   <= acc.store;
                if (state_nxt == WR) begin
                    mem.mem_wdata <= req_wdata;
                end
            end
            if ((state == RD) && mem.mem_ack) begin
                raw_rdata <= mem.mem_rdata;
            end
            if (state == WR_PREP) begin
                mem.mem_wdata <= sl_wd;
            end
        end
    end

endmodule

// File: doc/dmem_rmw_ctrl.md
Name: dmem_rmw_ctrl

Overview:
- Sequential data-memory access controller between the MEM-stage load/store alignment unit and the synchronous data RAM port.
- Issues word-aligned reads and writes, with a memory acknowledge of variable latency.
- Provides the raw read word that the alignment unit consumes, and accepts the merged write word that unit produces.
- Runs a read-modify-write sequence for sub-word stores and stalls the pipeline until the access completes.

Parameters:
- MAX_WAIT, 255, maximum cycles to wait for mem_ack in one state before a bus error is raised.
- WAIT_W, 8, width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  MEM stage has a memory instruction; held stable while stall=1
- req_addr  in  32  byte address
- dmem_access  in  4  [3]=store, [2]=sign-extend, [1:0]=size (00=B, 01=H, 10=W, 11=none)
- req_wdata  in  32  unaligned store data from register file
- sl_wd  in  32  merged write word returned by the alignment unit
- raw_rdata  out  32  registered raw memory word fed to the alignment unit
- stall  out  1  freeze the pipeline
- done  out  1  one-cycle pulse: the access has completed
- bus_err  out  1  one-cycle pulse with done when the access timed out
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_wdata  out  32  write word
- mem_ack  in  1  single-cycle acknowledge; mem_rdata valid in the same cycle for reads
- mem_rdata  in  32  read word

Behaviour:
- Reset: state=IDLE, wait counter=0, and every output is 0: raw_rdata, stall, done, bus_err, mem_req, mem_we, mem_addr, mem_wdata.
- Reset mid-operation:
  - mem_req drops immediately, since reset is asynchronous.
  - Any in-flight access is abandoned; no retry is made.
- States: IDLE, RD, WR, DONE.
- IDLE transitions:
  - req_valid=0 or size=11: stay in IDLE, stall=0. A size=11 request completes with no memory traffic.
  - Load, or store with size B/H: latch addr, access and wdata, then go to RD.
  - Store with size W: latch mem_wdata=req_wdata, then go to WR. No read is issued.
- stall is combinational:
  - 1 when in IDLE with req_valid=1 and size!=11.
  - 1 in RD and in WR.
  - 0 in DONE and otherwise.
- RD: mem_req=1, mem_we=0, mem_addr held.
  - On mem_ack: raw_rdata<=mem_rdata.
  - Then a load goes to DONE; a sub-word store goes to WR_PREP, with mem_wdata latched from sl_wd in the next cycle.
  - Implementation: WR is entered one cycle after the ack, so that sl_wd reflects the new raw_rdata. This one-cycle gap is a sub-state of WR with mem_req=0.
- WR: mem_req=1, mem_we=1; mem_addr and mem_wdata stay stable until mem_ack. On mem_ack go to DONE.
- DONE: done=1 for exactly one cycle, stall=0, then go to IDLE. The pipeline advances on this edge, so req_valid is ignored in DONE.
- Load latency: ack cycle + 2 cycles (ack, DONE). Sub-word store: read ack + 1 prep + write ack + DONE.
- mem_req, mem_we, mem_addr and mem_wdata are registered outputs, constant while waiting.
- Wait counter:
  - Cleared on every state entry; increments each cycle in RD or WR without mem_ack.
  - On reaching MAX_WAIT: go to DONE with bus_err=1. raw_rdata is unchanged and no write occurs.
- raw_rdata holds its value until the next read ack.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, a halfword with addr[0]=1 or a word with addr[1:0]!=0 triggers a trap.
  - The block then goes straight to DONE with done=1 and misalign=1, an extra 1-bit output that is 0 at reset. No memory request is made.
- Undefined:
  - No misalign port; misaligned addresses are accessed at the aligned word.

Decomposition:
- Shared package/header:
  - state encodings IDLE/RD/WR_PREP/WR/DONE;
  - dmem_access field positions and the size codes SZ_B=00, SZ_H=01, SZ_W=10, SZ_NONE=11.
- Submodule dmem_wait_timer: counter with clear, enable, and an expired flag.

Test Plan:
- LW 0x100, mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> raw_rdata=0xDEADBEEF, stall high 4 cycles, done pulse, one read, no write.
- SB addr 0x203, wdata 0x55, read word 0x11223344, sl_wd=0x55223344 -> write to 0x200 with 0x55223344, one read then one write.
- SW 0x300 data 0xCAFEF00D, ack next cycle -> no read, write 0xCAFEF00D to 0x300, done two cycles after request.
- mem_ack never asserted, MAX_WAIT=4 -> after 4 wait cycles: bus_err=1 with done, then IDLE.
- rst asserted during WR -> mem_req=0 within the same cycle; after release: IDLE, all outputs 0, next request serviced normally.
- With DMEM_MISALIGN_TRAP_EN, LH addr 0x101 -> misalign=1 and done=1 one cycle later, mem_req never asserted.
